// File: rtl/mux16_rr_sched_if.sv
// ---------------------------------------------------------------------------
// mux16_rr_sched_if : request/grant/select bundle between requesters and scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mux16_rr_sched_if;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic        s0;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        busy;

  modport master (
    output en, req,
    input  gnt, s0, s1, s2, s3, busy
  );

  modport slave (
    input  en, req,
    output gnt, s0, s1, s2, s3, busy
  );
endinterface

`default_nettype wire

// File: rtl/mux16_rr_sched.sv
// ---------------------------------------------------------------------------
// mux16_rr_sched : round-robin owner of a 16:1 mux with bounded hold time
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux16_rr_sched #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  mux16_rr_sched_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned    HOLD_LAST_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0]     HOLD_LAST     = HOLD_LAST_INT[7:0];

  state_t      state, state_n;
  logic [3:0]  sel, sel_n;
  logic [3:0]  ptr, ptr_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] gnt, gnt_n;
  logic        busy, busy_n;
  logic [4:0]  first_hit;
  logic [4:0]  next_hit;
  logic [3:0]  sel_inc;

  // Returns {found, index}; scanning downward lets the smallest offset win.
  function automatic logic [4:0] search(input logic [15:0] r,
                                        input logic [3:0]  start,
                                        input logic        use_mask,
                                        input logic [3:0]  mask_idx);
    logic [3:0] idx;
    logic [4:0] res;
    res = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = start + 4'(i);
      if (r[idx] && !(use_mask && (idx == mask_idx)))
        res = {1'b1, idx};
    end
    return res;
  endfunction

  assign sel_inc   = sel + 4'd1;
  assign first_hit = search(bus.req, ptr, 1'b0, 4'd0);
  assign next_hit  = search(bus.req, sel_inc, 1'b1, sel);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        gnt_n = 16'd0;
        if (bus.en && (|bus.req)) begin
          sel_n   = first_hit[3:0];
          gnt_n   = 16'd1 << first_hit[3:0];
          cnt_n   = 8'd0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          gnt_n   = 16'd0;
          ptr_n   = sel_inc;
          state_n = IDLE;
        end else if (!bus.req[sel]) begin
          ptr_n = sel_inc;
          cnt_n = 8'd0;
          if (next_hit[4]) begin
            sel_n = next_hit[3:0];
            gnt_n = 16'd1 << next_hit[3:0];
          end else begin
            gnt_n   = 16'd0;
            state_n = IDLE;
          end
        end else if ((MAX_HOLD != 0) && (cnt == HOLD_LAST)) begin
          // With no competitor the owner is simply re-granted.
          ptr_n = sel_inc;
          cnt_n = 8'd0;
          if (next_hit[4]) begin
            sel_n = next_hit[3:0];
            gnt_n = 16'd1 << next_hit[3:0];
          end
        end else if (cnt != 8'hFF) begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        gnt_n   = 16'd0;
        state_n = IDLE;
      end
    endcase
    busy_n = |gnt_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 4'd0;
      ptr   <= 4'd0;
      cnt   <= 8'd0;
      gnt   <= 16'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
    end
  end

  assign bus.gnt  = gnt;
  assign bus.busy = busy;
  assign bus.s0   = sel[0];
  assign bus.s1   = sel[1];
  assign bus.s2   = sel[2];
  assign bus.s3   = sel[3];

endmodule

`default_nettype wire

// File: tb/tb_mux16_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_mux16_rr_sched : directed tests for mux16_rr_sched at MAX_HOLD = 8, 2, 4
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] req;
  logic [15:0] d = 16'hAAAA;
  int          tests  = 0;
  int          failed = 0;

  mux16_rr_sched_if b8 ();
  mux16_rr_sched_if b2 ();
  mux16_rr_sched_if b4 ();

  assign b8.en = en;
  assign b8.req = req;
  assign b2.en = en;
  assign b2.req = req;
  assign b4.en = en;
  assign b4.req = req;

  mux16_rr_sched #(.MAX_HOLD(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  mux16_rr_sched #(.MAX_HOLD(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  mux16_rr_sched #(.MAX_HOLD(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

  logic [3:0] sel8, sel2, sel4;
  logic       y8;
  assign sel8 = {b8.s3, b8.s2, b8.s1, b8.s0};
  assign sel2 = {b2.s3, b2.s2, b2.s1, b2.s0};
  assign sel4 = {b4.s3, b4.s2, b4.s1, b4.s0};
  assign y8   = d[sel8];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    req   = 16'd0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) reset = 1'b0;
      step();
      tests++;
      if (b8.gnt !== 16'd0 || b8.busy !== 1'b0 || sel8 !== 4'd0) begin
        failed++;
        $display("FAIL reset_idle cyc%0d: gnt=%h busy=%b sel=%h, want 0/0/0", c, b8.gnt, b8.busy, sel8);
      end
    end
  endtask

  task automatic test_single();
    req = 16'h0020;
    for (int e = 1; e <= 3; e++) begin
      step();
      tests++;
      if (b8.gnt !== 16'h0020 || sel8 !== 4'd5 || y8 !== 1'b1 || b8.busy !== 1'b1) begin
        failed++;
        $display("FAIL single_grant edge%0d: gnt=%h sel=%h y=%b busy=%b, want 0020/5/1/1", e, b8.gnt, sel8, y8, b8.busy);
      end
    end
    req = 16'd0;
    step();
    tests++;
    if (b8.gnt !== 16'd0 || b8.busy !== 1'b0 || sel8 !== 4'd5) begin
      failed++;
      $display("FAIL single_release: gnt=%h busy=%b sel=%h, want 0000/0/5", b8.gnt, b8.busy, sel8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] reqs [5];
    logic [15:0] exp  [5];
    reqs = '{16'h0008, 16'h008A, 16'h0082, 16'h0002, 16'h0000};
    exp  = '{16'h0008, 16'h0008, 16'h0080, 16'h0002, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      step();
      tests++;
      if (b8.gnt !== exp[i] || b8.busy !== (exp[i] != 16'd0)) begin
        failed++;
        $display("FAIL back_to_back step%0d: gnt=%h busy=%b, want %h", i, b8.gnt, b8.busy, exp[i]);
      end
    end
  endtask

  task automatic test_enable_reset();
    req = 16'h0010;
    step();
    tests++;
    if (b8.gnt !== 16'h0010 || sel8 !== 4'd4) begin
      failed++;
      $display("FAIL en_grant: gnt=%h sel=%h, want 0010/4", b8.gnt, sel8);
    end
    en = 1'b0;
    step();
    tests++;
    if (b8.gnt !== 16'd0 || b8.busy !== 1'b0 || sel8 !== 4'd4) begin
      failed++;
      $display("FAIL en_drop: gnt=%h busy=%b sel=%h, want 0000/0/4", b8.gnt, b8.busy, sel8);
    end
    en = 1'b1;
    step();
    tests++;
    if (b8.gnt !== 16'h0010) begin
      failed++;
      $display("FAIL en_regrant: gnt=%h, want 0010", b8.gnt);
    end
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if (b8.gnt !== 16'd0 || b8.busy !== 1'b0 || sel8 !== 4'd0) begin
      failed++;
      $display("FAIL async_reset: gnt=%h busy=%b sel=%h, want 0000/0/0", b8.gnt, b8.busy, sel8);
    end
    step();
    reset = 1'b0;
    req   = 16'hFFFF;
    step();
    tests++;
    if (b8.gnt !== 16'h0001 || sel8 !== 4'd0 || b8.busy !== 1'b1) begin
      failed++;
      $display("FAIL post_reset_ptr: gnt=%h sel=%h busy=%b, want 0001/0/1", b8.gnt, sel8, b8.busy);
    end
    req = 16'd0;
    step();
  endtask

  task automatic test_rr_wrap();
    logic [3:0] exp_idx [6];
    exp_idx = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0};
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 16'h8001;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (b2.gnt !== (16'd1 << exp_idx[i]) || sel2 !== exp_idx[i] || b2.busy !== 1'b1) begin
        failed++;
        $display("FAIL rr_wrap edge%0d: gnt=%h sel=%h busy=%b, want idx %0d", i + 1, b2.gnt, sel2, b2.busy, exp_idx[i]);
      end
    end
    req = 16'd0;
    step();
  endtask

  task automatic test_lone_timeout();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 16'h0200;
    for (int i = 0; i < 12; i++) begin
      step();
      tests++;
      if (b4.gnt !== 16'h0200 || b4.busy !== 1'b1 || sel4 !== 4'd9) begin
        failed++;
        $display("FAIL lone_timeout edge%0d: gnt=%h busy=%b sel=%h, want 0200/1/9", i + 1, b4.gnt, b4.busy, sel4);
      end
    end
    req = 16'd0;
    step();
    tests++;
    if (b4.gnt !== 16'd0 || b4.busy !== 1'b0) begin
      failed++;
      $display("FAIL lone_release: gnt=%h busy=%b, want 0000/0", b4.gnt, b4.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_reset();
    test_rr_wrap();
    test_lone_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
